// File: rtl/serial_subtractor_32_bit.sv
//==============================================================================
// Module      : serial_subtractor_32_bit
// Description : Multi-cycle subtractor computing a - b - bin one DIGIT-bit
//               slice per clock, LSB first, with valid/ready on both sides.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor_32_bit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int c_n  = WIDTH / DIGIT;
  localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam int c_iw = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_acc_next;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_out_valid;
  logic [c_cw-1:0]  r_cnt;
  logic [c_iw-1:0]  w_base;
  logic [DIGIT-1:0] w_a_slice;
  logic [DIGIT-1:0] w_b_slice;
  logic [DIGIT:0]   w_sub;
  logic             w_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (in_valid) w_next = c_calc;
      c_calc:  if (w_last) w_next = c_done;
      c_done:  if (out_ready) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = (r_state == c_idle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_next == c_done);
    end
  end

  // One slice of the subtract; the extra top bit of w_sub is the slice borrow.
  always_comb begin
    w_last    = (r_cnt == c_last);
    w_base    = c_iw'(r_cnt) * c_iw'(DIGIT);
    w_a_slice = r_a[w_base +: DIGIT];
    w_b_slice = r_b[w_base +: DIGIT];
    w_sub     = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{DIGIT{1'b0}}, r_borrow};
    w_acc_next = r_acc;
    w_acc_next[w_base +: DIGIT] = w_sub[DIGIT-1:0];
  end

  // Partial result builds in r_acc so the visible diff only changes at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        c_calc: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_sub[DIGIT];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff <= w_acc_next;
            r_bout <= w_sub[DIGIT];
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                      (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: doc/serial_subtractor_32_bit.md
Name: serial_subtractor_32_bit

Overview:
- Multi-cycle unsigned/two's-complement subtractor, the inverse companion to the 32-bit ripple-carry adder.
- Computes diff = a - b - bin (mod 2^WIDTH) one DIGIT-bit slice per clock, LSB slice first.
- A borrow register chains the slices.
- Valid/ready handshakes on both sides, so it sits directly in the datapath alongside the adder with backpressure.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of DIGIT
DIGIT, 8, bits processed per cycle; N = WIDTH/DIGIT slice cycles (default N = 4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
a  input  WIDTH  minuend, sampled on accept
b  input  WIDTH  subtrahend, sampled on accept
bin  input  1  borrow-in, sampled on accept
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  borrow-out: 1 iff unsigned a < b + bin
ovf  output  1  signed overflow: (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB])
out_valid  output  1  diff/bout/ovf valid
out_ready  input  1  consumer takes result

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; diff = 0, bout = 0, ovf = 0, out_valid = 0.
  - Internal operand registers, borrow and slice counter are cleared.
  - in_ready = 1 while in IDLE, including immediately after reset.
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE), decoded from state; out_valid = (state == DONE), registered.
- IDLE:
  - At an edge with in_valid = 1, latch a, b and bin into internal registers, clear the slice counter, and go to CALC.
  - in_valid = 0 keeps the block in IDLE.
- CALC:
  - Each edge processes slice i = counter, covering bits [i*DIGIT +: DIGIT].
  - Slice result = a_slice - b_slice - borrow_reg; the result goes to diff_reg[slice] and the slice borrow goes to borrow_reg.
  - borrow_reg is initialised to bin at accept.
  - The counter increments by one per slice; after the edge processing slice N-1, bout = final borrow, ovf is computed from the latched a/b MSBs and the diff MSB, and the block goes to DONE.
- Latency: out_valid rises N edges after the accept edge, which is 4 cycles with the defaults. Throughput is one operation per N+2 cycles minimum.
- DONE:
  - diff, bout and ovf are held stable while out_valid = 1 and out_ready = 0, for any number of cycles.
  - The edge with out_ready = 1 returns the block to IDLE and drops out_valid.
  - No new accept occurs in the same edge, because in_ready = 0 in DONE.
- diff, bout and ovf retain their last values after the handshake until the next completion overwrites them. They are only meaningful while out_valid = 1.
- in_valid asserted during CALC or DONE is ignored; the upstream must hold it until in_ready = 1.
- Input changes after the accept edge do not affect the in-flight result.
- Arithmetic is modulo 2^WIDTH. Borrow propagates across slice boundaries exactly as in a full-width subtract.
- Reset asserted in CALC or DONE aborts the operation immediately: the result is lost and reset values are forced. After rst_n deasserts, the first edge may accept new operands.
- in_valid and out_ready are never both relevant in the same state, so there are no simultaneous-handshake cases.

Test Plan:
- a = 0x001F001F, b = 0x0006000C, bin = 0 -> diff = 0x00190013, bout = 0, ovf = 0, with out_valid exactly 4 cycles after accept.
- a = 0x00000000, b = 0x00000000, bin = 1 -> diff = 0xFFFFFFFF, bout = 1, ovf = 0. Wrap-around with borrow through all slices.
- a = 0xFFFFFFFF, b = 0x00000000, bin = 1 -> diff = 0xFFFFFFFE, bout = 0; then a = 0x00000100, b = 0x00000001, bin = 0 -> diff = 0x000000FF, bout = 0. Borrow crosses the slice boundary.
- a = 0x80000000, b = 0x00000001, bin = 0 -> diff = 0x7FFFFFFF, bout = 0, ovf = 1. Hold out_ready = 0 for 5 cycles: out_valid stays 1, diff stays stable, in_ready stays 0, and a pulsed in_valid with new operands is ignored. Raise out_ready: back to IDLE and in_ready = 1.
- Pull rst_n low asynchronously during the 2nd CALC cycle -> out_valid = 0, diff = 0, in_ready = 1 without a clock edge. Release, then accept a = 5, b = 7 -> diff = 0xFFFFFFFE, bout = 1.
